fir_filter_bank_seq: RTL and testbench

Parametrised, time-multiplexed successor to the fixed three-band FIR filter bank. Computes NUM_BANDS FIR outputs per input sample with one multiplier per band, iterating over taps sequentially. Coefficients are runtime-loadable, and valid/ready handshakes sit on both input and output. It sits between the audio sample source and the per-band gain/mix stage.

---
 rtl/fir_filter_bank_seq_if.sv | 43 ++++
 rtl/fir_filter_bank_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_fir_filter_bank_seq.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_filter_bank_seq_if.sv
// -----------------------------------------------------------------------------
// fir_filter_bank_seq_if
// Bundles the sample-input handshake, the coefficient write port and the
// band-output handshake of fir_filter_bank_seq.
//   slave  : the filter bank (consumes samples/coefficients, produces outputs)
//   master : the sample source / controller / downstream consumer side
// Signals:
//   in_valid/in_ready/in_sample         sample input handshake
//   coef_we/coef_band/coef_addr/coef_data  coefficient write port
//   coef_busy                           high while coefficient writes are ignored
//   out_valid/out_ready/out_bands       packed band-output handshake
// -----------------------------------------------------------------------------
interface fir_filter_bank_seq_if #(
    parameter int NUM_BANDS = 3,
    parameter int TAPS      = 101,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16
);
    localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int ADDR_W = $clog2(TAPS);

    logic                          in_valid;
    logic                          in_ready;
    logic signed [DATA_W-1:0]      in_sample;
    logic                          coef_we;
    logic [BAND_W-1:0]             coef_band;
    logic [ADDR_W-1:0]             coef_addr;
    logic signed [COEF_W-1:0]      coef_data;
    logic                          coef_busy;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_BANDS*DATA_W-1:0]   out_bands;

    modport slave (
        input  in_valid, in_sample, coef_we, coef_band, coef_addr, coef_data, out_ready,
        output in_ready, coef_busy, out_valid, out_bands
    );

    modport master (
        output in_valid, in_sample, coef_we, coef_band, coef_addr, coef_data, out_ready,
        input  in_ready, coef_busy, out_valid, out_bands
    );
endinterface

// File: rtl/fir_filter_bank_seq.sv
// -----------------------------------------------------------------------------
// fir_filter_bank_seq
// Time-multiplexed FIR filter bank: NUM_BANDS filters of TAPS taps each share
// one circular delay line. Each accepted sample is MAC'd one tap per cycle with
// one multiplier per band, then the accumulators are scaled by COEF_FRAC,
// saturated to DATA_W and presented on a valid/ready output.
//
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      fir_filter_bank_seq_if.slave (sample in, coefficient write, outputs)
//
// Build option:
//   FILTER_ROUND_EN  defined   -> round-half-up scaling before saturation
//                    undefined -> truncating (floor) scaling before saturation
// -----------------------------------------------------------------------------
module fir_filter_bank_seq #(
    parameter int NUM_BANDS = 3,
    parameter int TAPS      = 101,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 9,
    parameter int IN_SHIFT  = 5,
    parameter int ACC_W     = 40
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fir_filter_bank_seq_if.slave  bus
);

    localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int ADDR_W = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic [ADDR_W-1:0]    LAST_K    = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W:0]      TAPS_EXT  = (ADDR_W+1)'(TAPS);
    localparam logic [BAND_W:0]      BANDS_EXT = (BAND_W+1)'(NUM_BANDS);
    localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
    localparam logic signed [ACC_W:0] SAT_MIN  = ~SAT_MAX;
`ifdef FILTER_ROUND_EN
    localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(1) <<< (COEF_FRAC-1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Scale an accumulator down by COEF_FRAC and clamp it into DATA_W.
    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic signed [DATA_W-1:0] scale_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] shifted;
        ext = {acc[ACC_W-1], acc};
`ifdef FILTER_ROUND_EN
        ext = ext + RND_HALF;
`endif
        shifted = ext >>> COEF_FRAC;
        if (shifted > SAT_MAX) begin
            scale_sat = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            scale_sat = SAT_MIN[DATA_W-1:0];
        end else begin
            scale_sat = shifted[DATA_W-1:0];
        end
    endfunction

    state_t                       state_q, state_d;
    logic [ADDR_W-1:0]            k_q, k_d;
    logic [ADDR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic                         out_valid_q, out_valid_d;
    logic [NUM_BANDS*DATA_W-1:0]  out_bands_q, out_bands_d;
    logic signed [ACC_W-1:0]      acc_q [NUM_BANDS];
    logic signed [ACC_W-1:0]      acc_d [NUM_BANDS];
    logic signed [DATA_W-1:0]     dl_q  [TAPS];
    logic signed [COEF_W-1:0]     coef_q [NUM_BANDS][TAPS];

    logic                         accept_s;
    logic                         mac_s;
    logic                         load_out_s;
    logic                         release_s;
    logic                         coef_wr_s;
    logic signed [DATA_W-1:0]     x_s;
    logic [ADDR_W:0]              diff_s;
    logic [ADDR_W-1:0]            rd_idx_s;
    logic signed [DATA_W-1:0]     tap_s;
    logic signed [PROD_W-1:0]     prod_s [NUM_BANDS];

    assign accept_s   = (state_q == IDLE) && bus.in_valid;
    assign mac_s      = (state_q == MAC);
    // DONE is split in two by out_valid_q: first cycle loads outputs, then holds.
    assign load_out_s = (state_q == DONE) && !out_valid_q;
    assign release_s  = (state_q == DONE) && out_valid_q && bus.out_ready;
    assign coef_wr_s  = (state_q == IDLE) && bus.coef_we
                        && ({1'b0, bus.coef_band} < BANDS_EXT)
                        && ({1'b0, bus.coef_addr} < TAPS_EXT);
    assign x_s        = $signed(bus.in_sample) >>> IN_SHIFT;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.coef_busy = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_bands = out_bands_q;

    // Delay-line read address for tap k: (wr_ptr - k) mod TAPS.
    always_comb begin
        diff_s = '0;
        if (wr_ptr_q >= k_q) begin
            diff_s = {1'b0, wr_ptr_q} - {1'b0, k_q};
        end else begin
            diff_s = {1'b0, wr_ptr_q} + TAPS_EXT - {1'b0, k_q};
        end
        rd_idx_s = diff_s[ADDR_W-1:0];
        tap_s    = dl_q[rd_idx_s];
    end

    // FSM next-state, tap counter, write pointer and output handshake.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        wr_ptr_d    = wr_ptr_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = MAC;
                    k_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            MAC: begin
                if (k_q == LAST_K) begin
                    state_d = DONE;
                    k_d     = '0;
                end else begin
                    state_d = MAC;
                    k_d     = k_q + ADDR_W'(1);
                end
            end
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    wr_ptr_d    = (wr_ptr_q == LAST_K) ? '0 : wr_ptr_q + ADDR_W'(1);
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Per-band products, accumulator update and output load.
    always_comb begin
        out_bands_d = out_bands_q;
        for (int b = 0; b < NUM_BANDS; b++) begin
            prod_s[b] = PROD_W'(coef_q[b][k_q]) * PROD_W'(tap_s);
            if (accept_s) begin
                acc_d[b] = '0;
            end else if (mac_s) begin
                acc_d[b] = acc_q[b] + {{(ACC_W-PROD_W){prod_s[b][PROD_W-1]}}, prod_s[b]};
            end else begin
                acc_d[b] = acc_q[b];
            end
            if (load_out_s) begin
                out_bands_d[b*DATA_W +: DATA_W] = scale_sat(acc_q[b]);
            end else begin
                out_bands_d[b*DATA_W +: DATA_W] = out_bands_q[b*DATA_W +: DATA_W];
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            wr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_bands_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wr_ptr_q    <= wr_ptr_d;
            out_valid_q <= out_valid_d;
            out_bands_q <= out_bands_d;
        end
    end

    // Accumulators, one per band.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                acc_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                acc_q[b] <= acc_d[b];
            end
        end
    end

    // Circular delay line; the new sample lands at wr_ptr on the accepting edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) begin
                dl_q[k] <= '0;
            end
        end else if (accept_s) begin
            dl_q[wr_ptr_q] <= x_s;
        end
    end

    // Coefficient store; a write in the same edge as an accept is used by that sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                for (int k = 0; k < TAPS; k++) begin
                    coef_q[b][k] <= '0;
                end
            end
        end else if (coef_wr_s) begin
            coef_q[bus.coef_band][bus.coef_addr] <= bus.coef_data;
        end
    end

endmodule

// File: tb/tb_fir_filter_bank_seq.sv
module tb_fir_filter_bank_seq;

    localparam int NUM_BANDS = 3;
    localparam int TAPS      = 101;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 9;
    localparam int IN_SHIFT  = 5;
    localparam int ACC_W     = 40;
    localparam int BAND_W    = 2;
    localparam int ADDR_W    = 7;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    fir_filter_bank_seq_if #(.NUM_BANDS(NUM_BANDS), .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W)) bus();

    fir_filter_bank_seq #(
        .NUM_BANDS(NUM_BANDS), .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
        .COEF_FRAC(COEF_FRAC), .IN_SHIFT(IN_SHIFT), .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int coef_m [NUM_BANDS][TAPS];
    int hist [$];
    int last_out [NUM_BANDS];

    // Reference: direct convolution of the stored x' history, then scale and clamp.
    function automatic int ref_band(int b);
        longint acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            acc += longint'(coef_m[b][k]) * longint'(hist[k]);
        end
`ifdef FILTER_ROUND_EN
        acc += longint'(1) <<< (COEF_FRAC-1);
`endif
        acc = acc >>> COEF_FRAC;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    function automatic int got_band(int b);
        logic signed [DATA_W-1:0] v;
        v = bus.out_bands[b*DATA_W +: DATA_W];
        return int'(v);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NUM_BANDS; b++)
            for (int k = 0; k < TAPS; k++)
                coef_m[b][k] = 0;
        hist.delete();
        for (int k = 0; k < TAPS; k++) hist.push_back(0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        bus.out_ready = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    task automatic write_coef(input int b, input int a, input int d);
        bus.coef_we   = 1'b1;
        bus.coef_band = BAND_W'(b);
        bus.coef_addr = ADDR_W'(a);
        bus.coef_data = COEF_W'(d);
        @(posedge clk);
        #1 bus.coef_we = 1'b0;
        if (b < NUM_BANDS && a < TAPS) coef_m[b][a] = d;
    endtask

    // Accept one sample and wait for its output; checks latency and all bands.
    task automatic send_sample(input int s, input bit busy_wr, input bit cw_same,
                               input int cb, input int ca, input int cd);
        int lat;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL accept_ready: got %0b want 1", bus.in_ready);
        end
        bus.in_sample = DATA_W'(s);
        bus.in_valid  = 1'b1;
        if (cw_same) begin
            bus.coef_we   = 1'b1;
            bus.coef_band = BAND_W'(cb);
            bus.coef_addr = ADDR_W'(ca);
            bus.coef_data = COEF_W'(cd);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        if (cw_same && cb < NUM_BANDS && ca < TAPS) coef_m[cb][ca] = cd;
        hist.push_front(s >>> IN_SHIFT);
        void'(hist.pop_back());
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 3*TAPS) begin
            if (busy_wr && lat == 5) begin
                bus.coef_we   = 1'b1;
                bus.coef_band = BAND_W'(0);
                bus.coef_addr = ADDR_W'(0);
                bus.coef_data = COEF_W'(1234);
                total++;
                if (bus.coef_busy !== 1'b1) begin
                    bad++; $display("FAIL coef_busy_mac: got %0b want 1", bus.coef_busy);
                end
            end
            @(posedge clk);
            #1;
            bus.coef_we = 1'b0;
            lat++;
        end
        total++;
        if (lat != TAPS+1) begin
            bad++; $display("FAIL latency: got %0d want %0d", lat, TAPS+1);
        end
        for (int b = 0; b < NUM_BANDS; b++) begin
            last_out[b] = ref_band(b);
            total++;
            if (got_band(b) !== last_out[b]) begin
                bad++; $display("FAIL band%0d_model: got %0d want %0d", b, got_band(b), last_out[b]);
            end
        end
    endtask

    task automatic finish_output();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL release: got valid=%0b ready=%0b want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_bands !== '0 || bus.in_ready !== 1'b1 || bus.coef_busy !== 1'b0) begin
            bad++; $display("FAIL reset_state: got valid=%0b bands=%h ready=%0b busy=%0b want 0/0/1/0",
                            bus.out_valid, bus.out_bands, bus.in_ready, bus.coef_busy);
        end
    endtask

    task automatic test_impulse();
        int samples [5] = '{3200, 0, 0, 0, 0};
        int expect0 [5] = '{100, 200, 300, 400, 0};
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(0, k, 512*(k+1));
        for (int i = 0; i < 5; i++) begin
            send_sample(samples[i], 1'b0, 1'b0, 0, 0, 0);
            total++;
            if (got_band(0) !== expect0[i]) begin
                bad++; $display("FAIL impulse[%0d]: got %0d want %0d", i, got_band(0), expect0[i]);
            end
            finish_output();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(1, k, 32767);
        for (int i = 0; i < 2; i++) begin
            send_sample(32767, 1'b0, 1'b0, 0, 0, 0);
            total++;
            if (got_band(1) !== 32767) begin
                bad++; $display("FAIL sat_pos: got %0d want 32767", got_band(1));
            end
            finish_output();
        end
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(1, k, 32767);
        for (int i = 0; i < 2; i++) begin
            send_sample(-32768, 1'b0, 1'b0, 0, 0, 0);
            total++;
            if (got_band(1) !== -32768) begin
                bad++; $display("FAIL sat_neg: got %0d want -32768", got_band(1));
            end
            finish_output();
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        bus.in_sample = DATA_W'(12345);
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_bands !== '0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_mid: got valid=%0b bands=%h ready=%0b want 0/0/1",
                            bus.out_valid, bus.out_bands, bus.in_ready);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < TAPS+10; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_mid_stale: got %0d valid cycles ready=%0b want 0/1", seen, bus.in_ready);
        end
    endtask

    task automatic test_rounding();
        int exp_pos, exp_neg;
`ifdef FILTER_ROUND_EN
        exp_pos = 1;  exp_neg = 0;
`else
        exp_pos = 0;  exp_neg = -1;
`endif
        do_reset();
        write_coef(2, 0, 1);
        send_sample(256*32, 1'b0, 1'b0, 0, 0, 0);
        total++;
        if (got_band(2) !== exp_pos) begin
            bad++; $display("FAIL round_pos: got %0d want %0d", got_band(2), exp_pos);
        end
        finish_output();
        send_sample(-256*32, 1'b0, 1'b0, 0, 0, 0);
        total++;
        if (got_band(2) !== exp_neg) begin
            bad++; $display("FAIL round_neg: got %0d want %0d", got_band(2), exp_neg);
        end
        finish_output();
    endtask

    task automatic test_backpressure();
        int s;
        int first [NUM_BANDS];
        logic [NUM_BANDS*DATA_W-1:0] held;
        do_reset();
        write_coef(0, 0, 700);
        write_coef(1, 0, -300);
        write_coef(2, 0, 5);
        s = int'($urandom_range(65535)) - 32768;
        bus.out_ready = 1'b0;
        send_sample(s, 1'b1, 1'b0, 0, 0, 0);
        for (int b = 0; b < NUM_BANDS; b++) first[b] = got_band(b);
        held = bus.out_bands;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_bands !== held) begin
                bad++; $display("FAIL hold[%0d]: got valid=%0b ready=%0b bands=%h want 1/0/%h",
                                i, bus.out_valid, bus.in_ready, bus.out_bands, held);
            end
        end
        finish_output();
        send_sample(s, 1'b0, 1'b0, 0, 0, 0);
        for (int b = 0; b < NUM_BANDS; b++) begin
            total++;
            if (got_band(b) !== first[b]) begin
                bad++; $display("FAIL rerun_band%0d: got %0d want %0d", b, got_band(b), first[b]);
            end
        end
        finish_output();
    endtask

    task automatic test_random();
        do_reset();
        for (int b = 0; b < NUM_BANDS; b++)
            for (int k = 0; k < TAPS; k++)
                write_coef(b, k, int'($urandom_range(256)) - 128);
        write_coef(3, 0, 9999);
        write_coef(0, TAPS, 9999);
        for (int i = 0; i < 25; i++) begin
            bit cw;
            int wait_cycles;
            cw = ($urandom_range(2) == 0);
            wait_cycles = int'($urandom_range(3));
            bus.out_ready = (wait_cycles == 0);
            send_sample(int'($urandom_range(65535)) - 32768, 1'b0, cw,
                        int'($urandom_range(NUM_BANDS-1)), int'($urandom_range(TAPS-1)),
                        int'($urandom_range(256)) - 128);
            repeat (wait_cycles) @(posedge clk);
            if (wait_cycles != 0) #1;
            finish_output();
        end
    endtask

    task automatic test_wrap();
        int exp0;
        do_reset();
        write_coef(0, TAPS-1, 512);
        for (int n = 0; n < 3*TAPS; n++) begin
            send_sample(n*32, 1'b0, 1'b0, 0, 0, 0);
            exp0 = (n >= TAPS-1) ? n-(TAPS-1) : 0;
            total++;
            if (got_band(0) !== exp0) begin
                bad++; $display("FAIL wrap[%0d]: got %0d want %0d", n, got_band(0), exp0);
            end
            finish_output();
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.coef_we   = 1'b0;
        bus.coef_band = '0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_impulse();
        test_saturation();
        test_reset_mid();
        test_rounding();
        test_backpressure();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
